// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 decryption controller.
package aes_pkg;

  localparam int unsigned NR_AES128 = 10;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    LAST,
    DONE
  } dec_state_e;

endpackage

// File: rtl/aes_dec_round_unit.sv
// Inverse AES round datapaths (full round and final round) behind a single "last" select.
// Each datapath only sees non-zero operands while it is the selected, valid one.
module aes_dec_round_unit
  import aes_pkg::*;
(
  input  logic   valid_i,
  input  logic   last_i,
  input  block_t state_i,
  input  block_t key_i,
  output block_t state_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 via an addition chain; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  // Inverse S-box: inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // Byte 4*c+r sits at bits [127-8*(4c+r) -: 8]; row r rotates right by r columns.
  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic block_t inv_sub_bytes(input block_t s);
    block_t o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  block_t rnd_state, rnd_key, rnd_out;
  block_t lst_state, lst_key, lst_out;

  // Operand gating: the unselected datapath is held at all-zero inputs.
  always_comb begin
    rnd_state = (valid_i && !last_i) ? state_i : '0;
    rnd_key   = (valid_i && !last_i) ? key_i   : '0;
    lst_state = (valid_i &&  last_i) ? state_i : '0;
    lst_key   = (valid_i &&  last_i) ? key_i   : '0;
  end

  // decryptRound and decryptLastRound, then the result select.
  always_comb begin
    rnd_out = inv_mix_columns(inv_sub_bytes(inv_shift_rows(rnd_state)) ^ rnd_key);
    lst_out = inv_sub_bytes(inv_shift_rows(lst_state)) ^ lst_key;
    state_o = last_i ? lst_out : rnd_out;
  end

endmodule

// File: rtl/aes_decrypt_ctrl.sv
// Iterative AES decryption sequencer: one inverse round per clock, round keys fetched
// by index from the key-expansion store, valid/ready on both the input and output sides.
module aes_decrypt_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR   = NR_AES128,
  parameter int unsigned IDXW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_ready_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [127:0]    in_data_i,
  output logic [IDXW-1:0] rk_idx_o,
  input  logic [127:0]    rk_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [127:0]    out_data_o,
  output logic            busy_o
);

  localparam logic [IDXW-1:0] KeyIdxLast = IDXW'(NR);
  localparam logic [IDXW-1:0] CntInit    = IDXW'(NR - 1);
  localparam logic [IDXW-1:0] CntOne     = IDXW'(1);

  dec_state_e      state_q;
  logic [IDXW-1:0] cnt_q;
  block_t          data_q;
  logic            out_valid_q;
  logic            busy_q;

  logic   dp_valid;
  logic   dp_last;
  block_t dp_out;

  // Acceptance is only possible from IDLE with a complete key schedule.
  assign in_ready_o  = key_ready_i && !rst && (state_q == IDLE);
  assign dp_valid    = (state_q == ROUND) || (state_q == LAST);
  assign dp_last     = (state_q == LAST);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_valid_q ? data_q : '0;
  assign busy_o      = busy_q;

  // Round-key index: key NR for the initial AddRoundKey, counter in ROUND, key 0 in LAST.
  always_comb begin
    rk_idx_o = KeyIdxLast;
    unique case (state_q)
      IDLE:    rk_idx_o = KeyIdxLast;
      ROUND:   rk_idx_o = cnt_q;
      LAST:    rk_idx_o = '0;
      DONE:    rk_idx_o = KeyIdxLast;
      default: rk_idx_o = KeyIdxLast;
    endcase
  end

  aes_dec_round_unit u_round (
    .valid_i (dp_valid),
    .last_i  (dp_last),
    .state_i (data_q),
    .key_i   (rk_data_i),
    .state_o (dp_out)
  );

  // Controller FSM with registered out_valid and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i && in_ready_o) begin
            data_q  <= in_data_i ^ rk_data_i;
            cnt_q   <= CntInit;
            state_q <= ROUND;
            busy_q  <= 1'b1;
          end
        end
        ROUND: begin
          data_q <= dp_out;
          if (cnt_q == CntOne) begin
            state_q <= LAST;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        LAST: begin
          data_q      <= dp_out;
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready_i) begin
            data_q      <= '0;
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Self-checking bench for aes_decrypt_ctrl against a table-driven AES-128 reference model.
module tb_aes_decrypt_ctrl;

  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;

  logic         clk;
  logic         rst;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t   [256];
  logic [7:0]   isbox_t  [256];
  logic [127:0] rk       [16];

  aes_decrypt_ctrl #(.NR(10), .IDXW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_ready_i (key_ready),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .rk_idx_o    (rk_idx),
    .rk_data_i   (rk_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key store read port: same-cycle lookup.
  always_comb rk_data = rk[rk_idx];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int m_mul(input int a, input int b);
    int x, y, p;
    x = a; y = b; p = 0;
    while (y != 0) begin
      if ((y & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic int rol8(input int v, input int n);
    return ((v << n) | (v >> (8 - n))) & 255;
  endfunction

  task automatic build_tables();
    int inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (m_mul(x, y) == 1) inv = y;
      s = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 'h63;
      sbox_t[x]  = 8'(s);
      isbox_t[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    int rcon;
    rcon = 1;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {8'(rcon), 24'h0};
        rcon = m_mul(rcon, 2);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [127:0] k;
    int base [4];
    int acc;
    base = '{14, 11, 13, 9};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = ct[127-8*(4*c+r) -: 8] ^ rk[10][127-8*(4*c+r) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      k = rk[rnd];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][(c+r)%4] = s[r][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = isbox_t[t[r][c]] ^ k[127-8*(4*c+r) -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = 0;
            for (int j = 0; j < 4; j++) acc = acc ^ m_mul(base[(j+4-r)%4], int'(s[j][c]));
            t[r][c] = 8'(acc);
          end
        s = t;
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) model_decrypt[127-8*(4*c+r) -: 8] = s[r][c];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a block, wait (bounded) for acceptance, then for out_valid; ends in the DONE cycle.
  task automatic drive_block(input logic [127:0] ct, output logic [127:0] pt, output int lat,
                             output bit ok);
    int n;
    in_data = ct; in_valid = 1'b1; #1;
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    if (!in_ready) begin
      in_valid = 1'b0; ok = 1'b0; lat = 0; pt = '0;
      return;
    end
    tick(); in_valid = 1'b0; lat = 1; #1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    pt = out_data; ok = out_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; key_ready = 1'b1; in_valid = 1'b1; in_data = rand128(); out_ready = 1'b1;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (rk_idx !== 4'd10) begin errors++; $display("FAIL reset_rk_idx got %0d want 10", rk_idx); end
    rst = 1'b0; in_valid = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %0b want 1", in_ready); end
    tick();
  endtask

  task automatic test_fips();
    logic [3:0] want_idx;
    expand_key(FipsKey);
    out_ready = 1'b1; in_data = FipsCt; in_valid = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fips_accept got %0b want 1", in_ready); end
    checks++; if (rk_idx !== 4'd10) begin errors++; $display("FAIL fips_rk_idx0 got %0d want 10", rk_idx); end
    for (int cyc = 1; cyc <= 11; cyc++) begin
      tick(); in_valid = 1'b0; #1;
      if (cyc <= 10) begin
        want_idx = (cyc <= 9) ? 4'(10 - cyc) : 4'd0;
        checks++; if (rk_idx !== want_idx) begin errors++; $display("FAIL fips_rk_idx c%0d got %0d want %0d", cyc, rk_idx, want_idx); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fips_early_valid c%0d got %0b want 0", cyc, out_valid); end
      end else begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fips_latency got %0b want 1", out_valid); end
        checks++; if (out_data !== FipsPt) begin errors++; $display("FAIL fips_data got %h want %h", out_data, FipsPt); end
        checks++; if (out_data !== model_decrypt(FipsCt)) begin errors++; $display("FAIL fips_model got %h want %h", out_data, model_decrypt(FipsCt)); end
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fips_busy c%0d got %0b want 1", cyc, busy); end
    end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fips_idle_after got v%0b b%0b want v0 b0", out_valid, busy); end
  endtask

  task automatic test_backpressure();
    logic [127:0] ct1, ct2, pt;
    int lat;
    bit ok;
    expand_key(rand128());
    ct1 = rand128(); ct2 = rand128();
    out_ready = 1'b0;
    drive_block(ct1, pt, lat, ok);
    checks++; if (!ok || lat != 11) begin errors++; $display("FAIL bp_latency got ok%0b lat %0d want ok1 lat 11", ok, lat); end
    in_data = ct2; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (out_data !== model_decrypt(ct1) || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold c%0d got v%0b %h want v1 %h", i, out_valid, out_data, model_decrypt(ct1)); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d got %0b want 0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    tick(); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_next_accept got r%0b v%0b want r1 v0", in_ready, out_valid); end
    tick(); in_valid = 1'b0; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_second_busy got %0b want 1", busy); end
    lat = 1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    checks++; if (lat != 11 || out_data !== model_decrypt(ct2)) begin errors++; $display("FAIL bp_second got lat %0d %h want lat 11 %h", lat, out_data, model_decrypt(ct2)); end
    tick();
  endtask

  task automatic test_key_not_ready();
    logic [127:0] ct;
    int lat;
    ct = rand128();
    key_ready = 1'b0; in_valid = 1'b1; in_data = ct; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL nokey_accept c%0d got r%0b b%0b want r0 b0", i, in_ready, busy); end
      tick();
    end
    key_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nokey_raise got %0b want 1", in_ready); end
    tick(); in_valid = 1'b0; key_ready = 1'b0; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nokey_busy got %0b want 1", busy); end
    lat = 1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    checks++; if (lat != 11 || out_data !== model_decrypt(ct)) begin errors++; $display("FAIL nokey_drop_ignored got lat %0d %h want lat 11 %h", lat, out_data, model_decrypt(ct)); end
    key_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt;
    int lat;
    bit ok, rose;
    in_data = rand128(); in_valid = 1'b1; out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_accept got %0b want 1", in_ready); end
    tick(); in_valid = 1'b0;
    repeat (4) tick();
    checks++; if (rk_idx !== 4'd5) begin errors++; $display("FAIL rstmid_cnt got %0d want 5", rk_idx); end
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL rstmid_idle got b%0b v%0b %h want b0 v0 0", busy, out_valid, out_data); end
    checks++; if (rk_idx !== 4'd10) begin errors++; $display("FAIL rstmid_rk_idx got %0d want 10", rk_idx); end
    rose = 1'b0;
    for (int i = 0; i < 15; i++) begin if (out_valid) rose = 1'b1; tick(); end
    checks++; if (rose !== 1'b0) begin errors++; $display("FAIL rstmid_no_output got %0b want 0", rose); end
    expand_key(FipsKey);
    drive_block(FipsCt, pt, lat, ok);
    checks++; if (!ok || lat != 11 || pt !== FipsPt) begin errors++; $display("FAIL rstmid_fips got lat %0d %h want lat 11 %h", lat, pt, FipsPt); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] ct [3];
    logic [127:0] exp [3];
    int idx, phase, blk;
    bit acc, exp_busy, exp_ov, exp_rdy;
    expand_key(rand128());
    for (int i = 0; i < 3; i++) begin ct[i] = rand128(); exp[i] = model_decrypt(ct[i]); end
    out_ready = 1'b1; idx = 0;
    for (int cyc = 0; cyc <= 36; cyc++) begin
      in_valid = (idx < 3);
      in_data  = ct[(idx < 3) ? idx : 2];
      #1;
      phase = cyc % 12; blk = cyc / 12;
      exp_rdy  = (phase == 0);
      exp_busy = (cyc < 36) && (phase != 0);
      exp_ov   = (cyc < 36) && (phase == 11);
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready c%0d got %0b want %0b", cyc, in_ready, exp_rdy); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL b2b_busy c%0d got %0b want %0b", cyc, busy, exp_busy); end
      checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL b2b_out_valid c%0d got %0b want %0b", cyc, out_valid, exp_ov); end
      if (exp_ov) begin
        checks++; if (out_data !== exp[blk]) begin errors++; $display("FAIL b2b_data blk%0d got %h want %h", blk, out_data, exp[blk]); end
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_zero_gate();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_data = rand128(); #1;
      checks++; if (out_data !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL gate_out c%0d got v%0b %h want v0 0", i, out_valid, out_data); end
      checks++; if ((dut.u_round.rnd_state | dut.u_round.rnd_key | dut.u_round.lst_state | dut.u_round.lst_key) !== '0) begin
        errors++; $display("FAIL gate_dp_inputs c%0d got %h %h want 0", i, dut.u_round.rnd_state, dut.u_round.lst_key);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [127:0] ct, pt, want;
    int lat, d;
    bit ok;
    for (int n = 0; n < 4; n++) begin
      expand_key(rand128());
      ct = rand128(); want = model_decrypt(ct);
      out_ready = 1'b0;
      drive_block(ct, pt, lat, ok);
      checks++; if (!ok || lat != 11 || pt !== want) begin errors++; $display("FAIL rand%0d got lat %0d %h want lat 11 %h", n, lat, pt, want); end
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        tick();
        checks++; if (out_data !== want) begin errors++; $display("FAIL rand%0d_hold got %h want %h", n, out_data, want); end
      end
      out_ready = 1'b1;
      tick(); tick();
    end
  endtask

  initial begin
    rst = 1'b1; key_ready = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int r = 0; r < 16; r++) rk[r] = '0;
    build_tables();
    expand_key(FipsKey);
    test_reset();
    test_fips();
    test_backpressure();
    test_key_not_ready();
    test_reset_mid();
    test_back_to_back();
    test_zero_gate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
